// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main memory block interface.
package mem_if_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned IDX_W      = ADDR_W - OFFSET_W;
  localparam int unsigned NUM_BLOCKS = 64;
  localparam int unsigned CNT_W      = 4;

  // Responder FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request captured at accept time and held for the whole access
  typedef struct packed {
    logic              write;
    logic [IDX_W-1:0]  blk;
    logic [BLOCK_W-1:0] wdata;
  } mem_req_t;

  // Block index of a byte address; the in-block offset is dropped
  function automatic logic [IDX_W-1:0] blk_idx(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// 64 x 128-bit block storage: one synchronous write port, one registered read port.
module mem_block_array
  import mem_if_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   idx,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [NUM_BLOCKS];

  // Storage update; reset clears every block
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds its value until the next read
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Block-granular memory responder with programmable access latency.
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata,
  output logic               done,
  output logic               busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("main_memory_responder: LATENCY must be within 1..15");
  end

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] counter, counter_d;
  mem_req_t         cur, cur_d;
  logic             done_d, busy_d;
  logic             wr_en_c, rd_en_c;

  // Offset bits select a byte inside a block and do not matter here
  logic unused_offset;
  assign unused_offset = ^addr[OFFSET_W-1:0];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      cur     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      counter <= counter_d;
      cur     <= cur_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

  // Next-state, latency countdown and array strobes
  always_comb begin
    state_d   = state;
    counter_d = counter;
    cur_d     = cur;
    done_d    = 1'b0;
    busy_d    = busy;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          cur_d.write = mem_write;
          cur_d.blk   = blk_idx(addr);
          cur_d.wdata = wdata;
          counter_d   = CNT_W'(LATENCY - 1);
          busy_d      = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_d = 1'b1;
        if (counter != '0) begin
          counter_d = counter - CNT_W'(1);
        end else begin
          wr_en_c = cur.write;
          rd_en_c = !cur.write;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  mem_block_array u_array (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en_c),
    .rd_en (rd_en_c),
    .idx   (cur.blk),
    .wdata (cur.wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed + randomized bench for main_memory_responder (LATENCY=4 and LATENCY=1).
module tb_main_memory_responder;

  localparam int unsigned LAT = 4;

  logic         clk;
  logic         reset;
  logic         req, mem_write;
  logic [9:0]   addr;
  logic [127:0] wdata, rdata;
  logic         done, busy;

  logic         rst1, req1, mem_write1;
  logic [9:0]   addr1;
  logic [127:0] wdata1, rdata1;
  logic         done1, busy1;

  int total = 0;
  int bad   = 0;

  // Reference state: plain arrays of block contents and last read data
  logic [127:0] model_mem [64];
  logic [127:0] model_rdata;
  logic [127:0] model1_mem [64];
  logic [127:0] model1_rdata;

  main_memory_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy)
  );

  main_memory_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .req(req1), .mem_write(mem_write1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .done(done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the LATENCY=4 instance; optional noise on inputs during BUSY
  task automatic access(input logic wr, input logic [9:0] a, input logic [127:0] d,
                        input bit scramble);
    int unsigned b;
    b = int'(a[9:4]);
    req = 1'b1; mem_write = wr; addr = a; wdata = d;
    step();
    chk_bit("accept_busy", busy, 1'b1);
    chk_bit("accept_done", done, 1'b0);
    for (int k = 1; k < int'(LAT); k++) begin
      if (scramble) begin
        req       = 1'($urandom);
        mem_write = 1'b1;
        addr      = {6'd2, 4'($urandom)};
        wdata     = rand128();
      end
      step();
      chk_bit("wait_done", done, 1'b0);
      chk_bit("wait_busy", busy, 1'b1);
    end
    step();
    if (wr) model_mem[b] = d;
    else    model_rdata  = model_mem[b];
    chk_bit("done_pulse", done, 1'b1);
    chk_bit("done_busy", busy, 1'b1);
    chk_blk("done_rdata", rdata, model_rdata);
    req = 1'b0; mem_write = 1'b0;
    step();
    chk_bit("after_done", done, 1'b0);
    chk_bit("after_busy", busy, 1'b0);
    chk_blk("after_rdata", rdata, model_rdata);
  endtask

  initial begin
    logic         p_wr;
    int unsigned  p_blk;
    logic [127:0] p_data;
    logic [127:0] blk5_new;

    reset = 1'b1; rst1 = 1'b1;
    req = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; mem_write1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i]  = '0;
      model1_mem[i] = '0;
    end
    model_rdata = '0; model1_rdata = '0;
    p_wr = 1'b0; p_blk = 0; p_data = '0;

    step(); step();
    chk_blk("reset_rdata", rdata, 128'h0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    reset = 1'b0; rst1 = 1'b0;
    step();

    // Read of block 0 right after reset
    access(1'b0, 10'h000, '0, 1'b0);

    // Write block 42, read back with different offset bits
    access(1'b1, 10'h2A4, 128'hDEADBEEF_00000001_00000002_00000003, 1'b0);
    access(1'b0, 10'h2AC, '0, 1'b0);
    chk_blk("blk42_readback", rdata, 128'hDEADBEEF_00000001_00000002_00000003);

    // Offset extremes land in block 63
    access(1'b1, 10'h3F0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    access(1'b0, 10'h3FF, '0, 1'b0);

    // Read block 5, overwrite it (rdata must hold), then read the new data
    access(1'b1, 10'h050, 128'h5555, 1'b0);
    access(1'b0, 10'h050, '0, 1'b0);
    blk5_new = rand128();
    access(1'b1, 10'h058, blk5_new, 1'b0);
    chk_blk("blk5_rdata_held", rdata, 128'h5555);
    access(1'b0, 10'h05C, '0, 1'b0);
    chk_blk("blk5_new", rdata, blk5_new);

    // Inputs wiggled during a read of block 1 must not reach block 2
    access(1'b1, 10'h010, 128'h1111_AAAA, 1'b0);
    access(1'b1, 10'h020, 128'h2222_BBBB, 1'b0);
    access(1'b0, 10'h014, '0, 1'b1);
    chk_blk("toggle_rdata_blk1", rdata, 128'h1111_AAAA);
    access(1'b0, 10'h020, '0, 1'b0);
    chk_blk("toggle_blk2_untouched", rdata, 128'h2222_BBBB);

    // Reset in the third BUSY cycle of a write to block 7
    req = 1'b1; mem_write = 1'b1; addr = 10'h070; wdata = 128'h1;
    step();
    chk_bit("abort_accept_busy", busy, 1'b1);
    step(); step();
    reset = 1'b1; req = 1'b0; mem_write = 1'b0;
    step();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_rdata = '0;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk_blk("abort_rdata", rdata, 128'h0);
    reset = 1'b0;
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      step();
      chk_bit("abort_no_done", done, 1'b0);
    end
    access(1'b0, 10'h070, '0, 1'b0);
    chk_blk("abort_blk7_zero", rdata, 128'h0);

    // Randomized traffic over a narrow block range to hit read-after-write
    for (int n = 0; n < 40; n++) begin
      access(1'($urandom), {6'($urandom_range(0, 15)), 4'($urandom)}, rand128(), 1'($urandom));
    end

    // LATENCY=1 with req held high: accept / busy / done every 3 edges
    req1 = 1'b1;
    for (int k = 0; k < 48; k++) begin
      mem_write1 = 1'($urandom);
      addr1      = {6'($urandom_range(0, 7)), 4'($urandom)};
      wdata1     = rand128();
      if (k % 3 == 0) begin
        p_wr = mem_write1; p_blk = int'(addr1[9:4]); p_data = wdata1;
      end
      step();
      if (k % 3 == 1) begin
        if (p_wr) model1_mem[p_blk] = p_data;
        else      model1_rdata      = model1_mem[p_blk];
      end
      chk_bit("lat1_done", done1, 1'(k % 3 == 1));
      chk_bit("lat1_busy", busy1, 1'(k % 3 != 2));
      chk_blk("lat1_rdata", rdata1, model1_rdata);
    end
    req1 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Memory-side responder for the L1 data cache's block interface.
- Holds 1 KiB of main memory as 64 blocks of 128 bits.
- Serves whole-block reads (miss refills) and whole-block writes (write-through updates) under a req/done handshake, with programmable access latency.
- Sits between the cache and the top-level testbench/processor. It replaces the previous combinational memory model so that cache miss timing becomes observable in cycles.

Parameters:
- ADDR_W, 10, byte-address width from the cache.
- BLOCK_W, 128, block width in bits (4 words).
- OFFSET_W, 4, byte-in-block offset bits, ignored by the memory.
- LATENCY, 4, cycles from request accept to done; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from cache; sampled only in IDLE.
- mem_write  in  1  1 = block write, 0 = block read; sampled with req.
- addr  in  ADDR_W  byte address; block index = addr[9:4].
- wdata  in  BLOCK_W  block to write; sampled with req.
- rdata  out  BLOCK_W  block read data; valid when done=1 on a read, then held.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the accept cycle until done, inclusive.

Behaviour:
- Reset (synchronous, active-high):
  - Goes to IDLE.
  - Clears all 64 blocks to 0.
  - Sets rdata=0, done=0, busy=0, counter=0.
  - Reset during BUSY aborts the access: no write is committed and no done is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If req=1 at a clock edge, latch blk=addr[9:4], mem_write and wdata, then enter BUSY.
  - Load counter=LATENCY-1 and set busy=1.
  - Otherwise stay in IDLE.
- BUSY:
  - While counter != 0, decrement.
  - When counter == 0, execute the access:
    - Write: mem[blk] <= latched wdata.
    - Read: rdata <= mem[blk].
  - Then enter DONE.
- DONE:
  - done=1 and busy=1 for exactly this one cycle; rdata is valid.
  - Next state is IDLE, unconditionally.
- Timing:
  - done rises exactly LATENCY cycles after the accept edge.
  - With LATENCY=1, BUSY lasts 0 extra cycles: accept → BUSY (counter 0) → DONE at the next edge.
- req, addr, mem_write and wdata are ignored outside IDLE; nothing is queued.
  - The initiator must hold the request until done and drop req in the cycle done=1.
  - If req is still high in IDLE after DONE, it is accepted as a new request.
- rdata:
  - Holds its value until the next read completes.
  - Writes do not modify rdata, even to the same block.
- Read-after-write to the same block returns the newly written data; the write commits before DONE of the write.
- Address offset bits addr[3:0] have no effect: addresses 0x3F0 and 0x3FF hit the same block 63.
- Wrap-around: none. All 10-bit addresses map to valid blocks 0..63.
- Any LATENCY value outside 1..15 is an elaboration error.

Decomposition:
- Shared package mem_if_pkg:
  - ADDR_W, BLOCK_W, OFFSET_W, NUM_BLOCKS=64.
  - State encoding for IDLE/BUSY/DONE.
  - Block-index extraction constant, reused by the cache.
- One sub-module, mem_block_array:
  - 64x128 storage with synchronous reset-to-zero.
  - One synchronous write port and one registered read port.
  - Instantiated once.
- FSM and latency counter stay in the top module.

Test Plan:
- Reset with LATENCY=4, then read addr=0x000 → done pulses exactly 4 cycles after accept; rdata=128'h0; busy high for cycles 1..4 and low after.
- Write addr=0x2A4 (block 42), wdata=128'hDEADBEEF_00000001_00000002_00000003 → done after 4 cycles. Then read addr=0x2AC → rdata equals that same block (offset bits ignored).
- Read block 5, then write block 5 with new data → rdata keeps the old read value through the write and its done. A following read returns the new data.
- Toggle req/addr during BUSY of a read of block 1 to point at block 2 → only one done; rdata=block 1 contents; block 2 untouched.
- Assert reset during the 3rd BUSY cycle of a write to block 7 with data 128'h1 → no done. Next read of block 7 returns 0.
- Instantiate with LATENCY=1 and hold req high continuously → accept and DONE alternate, one completion every 3 cycles (IDLE/BUSY/DONE). Addresses sampled only in IDLE.
